// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // PC arithmetic wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, otherwise the contents hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [PC_W-1:0] load_pc4,
    input  logic [PC_W-1:0] load_instr,
    output logic [PC_W-1:0] pc4,
    output logic [PC_W-1:0] instr,
    output logic            valid
);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pc4   <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (bubble) begin
            pc4   <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc4   <= load_pc4;
            instr <= load_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, one-entry fetch buffer and IF/ID.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            pc_write_i,
    input  logic            ii_write_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [PC_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] ii_pc4_o,
    output logic [PC_W-1:0] ii_instr_o,
    output logic            ii_valid_o
);

    localparam logic [PC_W-1:0] RESET_PC_AL = {RESET_PC[PC_W-1:2], 2'b00};

    fetch_state_t    state;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] addr_r;
    logic            req_r;
    logic [PC_W-1:0] buf_pc;
    logic [PC_W-1:0] buf_instr;

    logic            adv;
    logic [PC_W-1:0] target;
    logic            ii_load;
    logic            ii_bubble;
    logic [PC_W-1:0] ld_pc4;
    logic [PC_W-1:0] ld_instr;

    // A mismatched PCWrite/IIWrite pair behaves like a full stall.
    assign adv    = pc_write_i & ii_write_i;
    assign target = word_align(branch_target_i);

    assign imem_req_o  = req_r;
    assign imem_addr_o = addr_r;
    assign pc_o        = pc_r;

    always_comb begin
        ii_load   = 1'b0;
        ii_bubble = 1'b0;
        ld_pc4    = pc_plus4(addr_r);
        ld_instr  = imem_rdata_i;
        if (branch_taken_i) begin
            ii_bubble = 1'b1;
        end else begin
            unique case (state)
                FETCH: begin
                    if (req_r) begin
                        if (imem_ready_i && adv) begin
                            ii_load = 1'b1;
                        end else if (!imem_ready_i && ii_write_i) begin
                            ii_bubble = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (adv) begin
                        ii_load  = 1'b1;
                        ld_pc4   = pc_plus4(buf_pc);
                        ld_instr = buf_instr;
                    end
                end
                DROP: begin
                    if (ii_write_i) begin
                        ii_bubble = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // req_r stays low for the first cycle after reset release so that a
    // stale ready during reset exit is never mistaken for a completed fetch.
    // In DROP, addr_r keeps the outstanding address while pc_r holds the
    // redirect target.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc_r      <= RESET_PC_AL;
            addr_r    <= RESET_PC_AL;
            req_r     <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= NOP_INSTR;
        end else if (branch_taken_i) begin
            pc_r <= target;
            if (state == DROP || (state == FETCH && req_r && !imem_ready_i)) begin
                state <= DROP;
                req_r <= 1'b1;
            end else begin
                state  <= FETCH;
                addr_r <= target;
                req_r  <= 1'b1;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                    end else if (imem_ready_i) begin
                        if (adv) begin
                            pc_r   <= pc_plus4(addr_r);
                            addr_r <= pc_plus4(addr_r);
                        end else begin
                            buf_pc    <= addr_r;
                            buf_instr <= imem_rdata_i;
                            state     <= HOLD;
                            req_r     <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (adv) begin
                        pc_r   <= pc_plus4(buf_pc);
                        addr_r <= pc_plus4(buf_pc);
                        state  <= FETCH;
                        req_r  <= 1'b1;
                    end
                end
                DROP: begin
                    if (imem_ready_i) begin
                        addr_r <= pc_r;
                        state  <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                    req_r <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .load       (ii_load),
        .bubble     (ii_bubble),
        .load_pc4   (ld_pc4),
        .load_instr (ld_instr),
        .pc4        (ii_pc4_o),
        .instr      (ii_instr_o),
        .valid      (ii_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: per-cycle IF/ID expectations are queued when driven.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int A_HOLD   = 0;
    localparam int A_LOAD   = 1;
    localparam int A_BUBBLE = 2;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
    } ii_exp_t;

    logic        clk_i;
    logic        rst_n;
    logic        pc_write_i;
    logic        ii_write_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] ii_pc4_o;
    logic [31:0] ii_instr_o;
    logic        ii_valid_o;

    int      checks;
    int      errors;
    ii_exp_t sb[$];
    ii_exp_t cur_exp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .pc_write_i      (pc_write_i),
        .ii_write_i      (ii_write_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rdata_i    (imem_rdata_i),
        .pc_o            (pc_o),
        .ii_pc4_o        (ii_pc4_o),
        .ii_instr_o      (ii_instr_o),
        .ii_valid_o      (ii_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not reach its end");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " req"}, {31'd0, imem_req_o}, 32'd0);
        checkOutput({tag, " pc"}, pc_o, 32'h0);
        checkOutput({tag, " valid"}, {31'd0, ii_valid_o}, 32'd0);
        checkOutput({tag, " instr"}, ii_instr_o, NOP);
        checkOutput({tag, " pc4"}, ii_pc4_o, 32'h0);
    endtask

    // Leaves the bench at the first cycle where the DUT issues its first request.
    task automatic do_reset();
        rst_n           = 1'b0;
        pc_write_i      = 1'b1;
        ii_write_i      = 1'b1;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        imem_ready_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        check_reset_values("in reset");
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        cur_exp = '{valid: 1'b0, instr: NOP, pc4: 32'h0, chk_pc4: 1'b1};
    endtask

    task automatic applyStimulus(
        input logic        pcw,
        input logic        iiw,
        input logic        br,
        input logic [31:0] tgt,
        input logic        rdy,
        input logic        exp_req,
        input logic [31:0] exp_addr,
        input logic [31:0] exp_pc,
        input int          act,
        input logic [31:0] ld_pc4,
        input logic [31:0] ld_instr
    );
        ii_exp_t e;
        pc_write_i      = pcw;
        ii_write_i      = iiw;
        branch_taken_i  = br;
        branch_target_i = tgt;
        imem_ready_i    = rdy;
        #1;
        checkOutput("imem_req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (exp_req) checkOutput("imem_addr", imem_addr_o, exp_addr);
        checkOutput("pc", pc_o, exp_pc);
        if (act == A_LOAD)
            cur_exp = '{valid: 1'b1, instr: ld_instr, pc4: ld_pc4, chk_pc4: 1'b1};
        else if (act == A_BUBBLE)
            cur_exp = '{valid: 1'b0, instr: NOP, pc4: 32'h0, chk_pc4: 1'b0};
        sb.push_back(cur_exp);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        checkOutput("ii_valid", {31'd0, ii_valid_o}, {31'd0, e.valid});
        checkOutput("ii_instr", ii_instr_o, e.instr);
        if (e.chk_pc4) checkOutput("ii_pc4", ii_pc4_o, e.pc4);
    endtask

    task automatic run_fetch(input logic [31:0] a);
        applyStimulus(1, 1, 0, 32'h0, 1, 1, a, a, A_LOAD, a + 32'd4, mem_word(a));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Zero-wait streaming from reset
        do_reset();
        run_fetch(32'h0);
        run_fetch(32'h4);
        run_fetch(32'h8);
        run_fetch(32'hC);
        #1;
        checkOutput("pc after stream", pc_o, 32'h10);

        // Load-use stall at PC=8, then a mismatched PCWrite/IIWrite pair at PC=C
        do_reset();
        run_fetch(32'h0);
        run_fetch(32'h4);
        applyStimulus(0, 0, 0, 32'h0, 1, 1, 32'h8, 32'h8, A_HOLD, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h8, A_LOAD, 32'hC, mem_word(32'h8));
        applyStimulus(1, 0, 0, 32'h0, 1, 1, 32'hC, 32'hC, A_HOLD, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'hC, A_LOAD, 32'h10, mem_word(32'hC));

        // Two wait states, then a wait cycle with IF/ID frozen
        applyStimulus(1, 1, 0, 32'h0, 0, 1, 32'h10, 32'h10, A_BUBBLE, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 1, 32'h10, 32'h10, A_BUBBLE, 32'h0, 32'h0);
        run_fetch(32'h10);
        applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h14, 32'h14, A_HOLD, 32'h0, 32'h0);
        run_fetch(32'h14);

        // Redirect with simultaneous stall; unaligned target bits are dropped
        applyStimulus(0, 0, 1, 32'h43, 1, 1, 32'h18, 32'h18, A_BUBBLE, 32'h0, 32'h0);
        run_fetch(32'h40);

        // Redirect to 0x10 discarding a same-cycle response, then redirect to 0x80
        // while the 3-wait request to 0x10 is outstanding
        applyStimulus(1, 1, 1, 32'h10, 1, 1, 32'h44, 32'h44, A_BUBBLE, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 1, 32'h10, 32'h10, A_BUBBLE, 32'h0, 32'h0);
        applyStimulus(1, 1, 1, 32'h80, 0, 1, 32'h10, 32'h10, A_BUBBLE, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0, 0, 1, 32'h10, 32'h80, A_BUBBLE, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0, 1, 1, 32'h10, 32'h80, A_BUBBLE, 32'h0, 32'h0);
        run_fetch(32'h80);

        // PC wrap at the top of the address space
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'h84, 32'h84, A_BUBBLE, 32'h0, 32'h0);
        run_fetch(32'hFFFF_FFFC);
        #1;
        checkOutput("pc after wrap", pc_o, 32'h0);

        // Asynchronous reset while a request is waiting
        imem_ready_i = 1'b0;
        #1;
        checkOutput("req before pulse", {31'd0, imem_req_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async pulse");
        do_reset();
        run_fetch(32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline, directly upstream of the hazard-detection unit and the ID stage.
- Owns the PC register, the instruction-memory request handshake, a one-entry fetch buffer and the IF/ID pipeline register.
- Obeys the hazard unit's PCWrite/IIWrite stall signals.
- Obeys branch-taken redirect/flush from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on a bubble or flush.

Ports:
clk_i  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
pc_write_i  input  1  from hazard unit (PCWrite); 0 = freeze PC.
ii_write_i  input  1  from hazard unit (IIWrite); 0 = freeze IF/ID.
branch_taken_i  input  1  redirect request; flushes IF/ID.
branch_target_i  input  32  redirect PC, valid when branch_taken_i=1.
imem_req_o  output  1  instruction-memory request.
imem_addr_o  output  32  request address; word aligned; stable while imem_req_o=1 and imem_ready_i=0.
imem_ready_i  input  1  read data valid; completes the request the same cycle.
imem_rdata_i  input  32  instruction word.
pc_o  output  32  current fetch PC.
ii_pc4_o  output  32  IF/ID: PC+4 of the held instruction.
ii_instr_o  output  32  IF/ID: instruction word.
ii_valid_o  output  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
Reset (async assert, sync release):
- pc_o=RESET_PC, state=FETCH, buffer empty.
- ii_valid_o=0, ii_instr_o=NOP_INSTR, ii_pc4_o=0.
- imem_req_o=0 during reset; imem_req_o=1 on the first cycle after release.

Transfer enable: adv = pc_write_i & ii_write_i. A mismatched pair is treated as a stall.

State FETCH (imem_req_o=1, imem_addr_o=req_addr):
- imem_ready_i=1 and adv=1:
  - IF/ID <= {req_addr+4, imem_rdata_i, valid=1}.
  - PC <= req_addr+4; next request issues next cycle.
  - Throughput is 1 instruction/cycle with zero-wait memory; latency is fetch-to-IF/ID 1 edge.
- imem_ready_i=1 and adv=0: capture word into buffer; go to HOLD.
- imem_ready_i=0 and ii_write_i=1: IF/ID <= bubble (valid=0, NOP_INSTR).
- imem_ready_i=0 and ii_write_i=0: IF/ID holds.

State HOLD (imem_req_o=0):
- IF/ID holds while adv=0.
- When adv=1: IF/ID <= buffer contents, PC <= buffered PC+4, buffer cleared, go to FETCH.

State DROP (imem_req_o=1, address unchanged):
- Entered when a redirect arrives while a request is outstanding (FETCH, imem_ready_i=0).
- Waits for imem_ready_i; the returned word is discarded; then go to FETCH at the redirected PC.

branch_taken_i=1 has top priority, regardless of pc_write_i/ii_write_i:
- PC <= branch_target_i.
- IF/ID <= bubble.
- Buffer cleared; HOLD goes to FETCH.
- A same-cycle imem_ready_i response is discarded.
- An outstanding unanswered request goes to DROP.
- branch_taken_i during DROP: update the target only; stay in DROP.

Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). Bits [1:0] of branch_target_i are forced to 0.

Reset asserted mid-request: the state is abandoned; the memory sees imem_req_o drop; no response is expected.

Decomposition:
- Package fetch_pkg: state enum {FETCH, HOLD, DROP}, NOP_INSTR default, PC width constant 32.
- One natural sub-module, if_id_reg: the IF/ID register with load/bubble/hold controls and async active-low reset.
- The FSM, PC and buffer stay in fetch_stage.

Test Plan:
1. Reset, zero-wait memory (ready tied 1), adv=1 for 4 cycles -> addresses 0,4,8,C; ii_instr_o follows one cycle later with ii_valid_o=1; ii_pc4_o=4,8,C,10.
2. Load-use stall: pc_write_i=ii_write_i=0 for 1 cycle at PC=8 -> PC holds 8; IF/ID holds the word from addr 4; instr@8 enters IF/ID after release with no refetch.
3. Memory with 2 wait states, adv=1 -> imem_addr_o stable for 3 cycles; 2 bubbles (valid=0, NOP_INSTR) inserted; then valid instr.
4. branch_taken_i=1, target=32'h40, with simultaneous stall -> next cycle PC=40, ii_valid_o=0; next request address 40.
5. Redirect to 32'h80 while a 3-wait request to 0x10 is outstanding -> state DROP; data for 0x10 never reaches IF/ID; next request address 80.
6. PC=32'hFFFF_FFFC, fetch -> ii_pc4_o=0, next PC=0; async rst_n pulse mid-request -> outputs reset immediately, imem_req_o=0.
